// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: mode values and breathe direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler producing a registered one-cycle pulse every DIV clocks.
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("tick_divider: DIV must be at least 2");
  end

  logic [CW-1:0] pre_cnt;

  // tick is registered from the wrap compare, so it is high in cycle DIV, 2*DIV, ...
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == CW'(DIV - 1));
      pre_cnt <= (pre_cnt == CW'(DIV - 1)) ? '0 : pre_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: blink, chase, PWM breathe and off,
// with the requested mode captured only on step boundaries.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int STEP_TICKS  = 250,
  parameter int NUM_LEDS    = 4,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] q,
  output logic                tick
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int SW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;

  if (DIV < 2) begin : g_bad_div
    $error("led_pattern_gen: CLK_FREQ_HZ / TICK_HZ must be at least 2");
  end
  if (STEP_TICKS < 1) begin : g_bad_step
    $error("led_pattern_gen: STEP_TICKS must be at least 1");
  end
  if (NUM_LEDS < 1) begin : g_bad_leds
    $error("led_pattern_gen: NUM_LEDS must be at least 1");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm
    $error("led_pattern_gen: PWM_BITS must be at least 1");
  end

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [SW-1:0]       step_cnt;
  logic                step;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_reg, duty_next;
  logic                dir_reg, dir_next;
  mode_t               mode_reg, mode_next;
  logic [NUM_LEDS-1:0] q_next;
  logic [NUM_LEDS-1:0] q_rot;
  mode_t               mode_in;

  assign step    = tick && (step_cnt == SW'(STEP_TICKS - 1));
  assign mode_in = mode_t'(mode);

  if (NUM_LEDS == 1) begin : g_rot_single
    assign q_rot = q;
  end else begin : g_rot_multi
    assign q_rot = {q[NUM_LEDS-2:0], q[NUM_LEDS-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      pwm_cnt  <= '0;
      duty_reg <= '0;
      dir_reg  <= DIR_UP;
      mode_reg <= MODE_BLINK;
      q        <= '0;
    end else begin
      if (tick) begin
        step_cnt <= (step_cnt == SW'(STEP_TICKS - 1)) ? '0 : step_cnt + SW'(1);
      end
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      duty_reg <= duty_next;
      dir_reg  <= dir_next;
      mode_reg <= mode_next;
      q        <= q_next;
    end
  end

  always_comb begin
    mode_next = mode_reg;
    q_next    = q;
    duty_next = duty_reg;
    dir_next  = dir_reg;
    // Entering a new mode wins over any step action in the same cycle.
    if (step && (mode_in != mode_reg)) begin
      mode_next = mode_in;
      q_next    = '0;
      if (mode_in == MODE_CHASE) begin
        q_next = NUM_LEDS'(1);
      end
      if (mode_in == MODE_BREATHE) begin
        duty_next = '0;
        dir_next  = DIR_UP;
      end
    end else begin
      unique case (mode_reg)
        MODE_BLINK: if (step) q_next = ~q;
        MODE_CHASE: if (step) q_next = q_rot;
        MODE_BREATHE: begin
          if (tick) begin
            if (dir_reg == DIR_UP) begin
              if (duty_reg == MAX) begin
                dir_next  = DIR_DOWN;
                duty_next = MAX - PWM_BITS'(1);
              end else begin
                duty_next = duty_reg + PWM_BITS'(1);
              end
            end else begin
              if (duty_reg == '0) begin
                dir_next  = DIR_UP;
                duty_next = PWM_BITS'(1);
              end else begin
                duty_next = duty_reg - PWM_BITS'(1);
              end
            end
          end
          q_next = {NUM_LEDS{pwm_cnt < duty_reg}};
        end
        default: q_next = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: cycle-indexed pattern model plus directed literal checks.
module tb_led_pattern_gen;

  localparam int DIV  = 10;
  localparam int STEP = 4;
  localparam int PER  = DIV * STEP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] q;
  logic       tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [1:0] m_mode  = 2'd0;
  logic [3:0] m_pat   = 4'h0;
  int         m_entry = 0;

  led_pattern_gen #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .STEP_TICKS  (STEP),
    .NUM_LEDS    (4),
    .PWM_BITS    (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .q    (q),
    .tick (tick)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset release; cycle n is the period after edge n.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Breathe output: duty follows a triangle over ticks since entry, compared to a free-running 3-bit counter.
  function automatic logic [3:0] breathe_q(input int k, input int entry);
    int n, t, d;
    if (k <= entry + 1) return 4'h0;
    n = (k - 2 - entry) / DIV;
    t = n % 14;
    d = (t <= 7) ? t : 14 - t;
    return (((k - 1) % 8) < d) ? 4'hF : 4'h0;
  endfunction

  always @(negedge clk) begin
    logic [3:0] exp_q;
    if (rst) begin
      m_mode  = 2'd0;
      m_pat   = 4'h0;
      m_entry = 0;
    end else begin
      check("tick_model", {31'd0, tick}, {31'd0, (cyc > 0) && (cyc % DIV == 0)});
      exp_q = (m_mode == 2'd2) ? breathe_q(cyc, m_entry) : m_pat;
      check("q_model", {28'd0, q}, {28'd0, exp_q});
      if (cyc > 0 && cyc % PER == 0) begin
        if (mode != m_mode) begin
          m_mode  = mode;
          m_entry = cyc;
          m_pat   = (mode == 2'd1) ? 4'h1 : 4'h0;
        end else begin
          case (m_mode)
            2'd0:    m_pat = ~m_pat;
            2'd1:    m_pat = {m_pat[2:0], m_pat[3]};
            2'd3:    m_pat = 4'h0;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_bound", {31'd0, cyc == n}, 32'd1);
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst  = 1'b1;
    mode = m;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic lit_q(input string name, input int n, input logic [3:0] exp);
    wait_cyc(n);
    check(name, {28'd0, q}, {28'd0, exp});
  endtask

  initial begin
    int high_cnt;

    // Reset, tick timing, blink, then change to OFF while lit
    do_reset(2'd0);
    check("reset_q", {28'd0, q}, 32'd0);
    check("reset_tick", {31'd0, tick}, 32'd0);
    wait_cyc(9);
    check("tick_c9", {31'd0, tick}, 32'd0);
    wait_cyc(10);
    check("tick_c10", {31'd0, tick}, 32'd1);
    wait_cyc(20);
    check("tick_c20", {31'd0, tick}, 32'd1);
    lit_q("blink_c40", 40, 4'h0);
    lit_q("blink_c41", 41, 4'hF);
    lit_q("blink_c81", 81, 4'h0);
    wait_cyc(130);
    #1 mode = 2'd3;
    lit_q("off_c160", 160, 4'hF);
    lit_q("off_c161", 161, 4'h0);
    lit_q("off_c241", 241, 4'h0);
    $display("txn blink/off done cycle=%0d", cyc);

    // Chase with a glitch between steps, then async reset mid-run
    do_reset(2'd1);
    lit_q("chase_c40", 40, 4'h0);
    lit_q("chase_c41", 41, 4'h1);
    lit_q("chase_c81", 81, 4'h2);
    lit_q("chase_c121", 121, 4'h4);
    lit_q("chase_c161", 161, 4'h8);
    lit_q("chase_c201", 201, 4'h1);
    wait_cyc(215);
    #1 mode = 2'd3;
    wait_cyc(225);
    #1 mode = 2'd1;
    lit_q("glitch_c241", 241, 4'h2);
    lit_q("chase_c300", 300, 4'h4);
    #2 rst = 1'b1;
    #1;
    check("async_q", {28'd0, q}, 32'd0);
    check("async_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_cyc(9);
    check("post_tick_c9", {31'd0, tick}, 32'd0);
    wait_cyc(10);
    check("post_tick_c10", {31'd0, tick}, 32'd1);
    lit_q("post_chase_c41", 41, 4'h1);
    $display("txn chase/reset done cycle=%0d", cyc);

    // Breathe: duty 3 window, full-duty window, then wrap through a full triangle
    do_reset(2'd2);
    lit_q("breathe_c41", 41, 4'h0);
    high_cnt = 0;
    for (int k = 72; k <= 79; k++) begin
      wait_cyc(k);
      if (q == 4'hF) high_cnt++;
    end
    check("breathe_duty3", high_cnt, 32'd3);
    lit_q("breathe_c120", 120, 4'h0);
    lit_q("breathe_c121", 121, 4'hF);
    wait_cyc(230);
    #1 mode = 2'd0;
    wait_cyc(250);
    $display("txn breathe done cycle=%0d", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
